// File: rtl/mips_pkg.sv
// Shared widths and types for the 16-bit MIPS pipeline.
// fetch_entry_t is the {pc, inst} pair handed from fetch to the IF/ID register.
package mips_pkg;

    localparam int INST_W     = 16;
    localparam int PC_W       = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head view and a one-cycle flush.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Flush wins over any push or pop issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues in-order imem requests under a credit limit,
// pairs responses with their PCs and buffers them for the IF/ID register.
module if_fetch_unit
    import mips_pkg::PC_W, mips_pkg::INST_W, mips_pkg::fetch_entry_t;
#(
    parameter int                DEPTH    = 2,
    parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
    parameter logic [INST_W-1:0] NOP_INST = mips_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              id_stall,
    output logic              fetch_valid,
    output logic [INST_W-1:0] fetch_inst,
    output logic [PC_W-1:0]   fetch_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [CW-1:0]   in_flight_reg;
    logic [CW-1:0]   in_flight_next;
    logic [CW-1:0]   pcq_count;
    logic [CW-1:0]   ofifo_count;
    logic [PC_W-1:0] pcq_head;
    fetch_entry_t    ofifo_head;
    fetch_entry_t    ofifo_din;
    logic [CW:0]     credits_used;
    logic            credit_ok;
    logic            accept;
    logic            resp;
    logic            stale;
    logic            resp_keep;
    logic            ofifo_pop;

    // Outstanding requests plus buffered instructions share one credit pool,
    // which is what keeps the output FIFO from ever overflowing.
    assign credits_used = {1'b0, in_flight_reg} + {1'b0, ofifo_count};
    assign credit_ok    = (credits_used < (CW+1)'(DEPTH));

    assign imem_req  = !rst && !redirect && credit_ok;
    assign imem_addr = pc_reg;
    assign accept    = imem_req && imem_ready;
    assign resp      = imem_rvalid && (in_flight_reg != '0);

    // Responses older than the last redirect have no PC left in the queue.
    assign stale     = (in_flight_reg > pcq_count);
    assign resp_keep = resp && !stale && !redirect;

    assign fetch_valid = (ofifo_count != '0);
    assign ofifo_pop   = fetch_valid && !id_stall && !redirect;

    assign ofifo_din.pc   = pcq_head;
    assign ofifo_din.inst = imem_rdata;

    always_comb begin
        in_flight_next = in_flight_reg;
        case ({accept, resp})
            2'b10:   in_flight_next = in_flight_reg + 1'b1;
            2'b01:   in_flight_next = in_flight_reg - 1'b1;
            default: in_flight_next = in_flight_reg;
        endcase
    end

    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (accept) begin
            pc_next = pc_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            in_flight_reg <= '0;
        end else begin
            pc_reg        <= pc_next;
            in_flight_reg <= in_flight_next;
        end
    end

    sync_fifo #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) pcq (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (resp_keep),
        .flush (redirect),
        .din   (pc_reg),
        .head  (pcq_head),
        .count (pcq_count)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) ofifo (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_keep),
        .pop   (ofifo_pop),
        .flush (redirect),
        .din   (ofifo_din),
        .head  (ofifo_head),
        .count (ofifo_count)
    );

    assign fetch_inst = fetch_valid ? ofifo_head.inst : NOP_INST;
    assign fetch_pc   = fetch_valid ? ofifo_head.pc   : '0;

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (in_flight_reg == '0)));

    a_in_flight_bound: assert property (@(posedge clk) disable iff (rst)
        (in_flight_reg <= CW'(DEPTH)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model, queue-based fetch reference,
// a directed vector table and hand sequences for redirect, wrap and reset.
module tb_if_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_stall;
    logic        fetch_valid;
    logic [15:0] fetch_inst;
    logic [15:0] fetch_pc;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_stall    (id_stall),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_pc    (fetch_pc)
    );

    typedef struct {
        logic [15:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } fe_t;

    typedef struct {
        logic        ready;
        logic        stall;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_pc;
    } vec_t;

    mreq_t       mem_q[$];
    fe_t         out_q[$];
    vec_t        tbl[18];
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    logic [15:0] m_pc = RESET_PC;
    int          errors = 0;
    int          checks = 0;

    logic        obs_req, obs_valid;
    logic [15:0] obs_addr, obs_pc, obs_inst;
    logic        hold_prev = 1'b0;
    logic [15:0] addr_prev = '0;
    logic        watch = 1'b0, bad_seen = 1'b0, saw_wrap = 1'b0, have_prev_pop = 1'b0;
    logic [15:0] prev_pop = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare against the reference at +1, advance the model at posedge.
    task automatic step(input logic r, input logic rdy, input logic stl, input logic rd,
                        input logic [15:0] rpc);
        logic  rv, exp_req, acc, pop;
        mreq_t head;
        fe_t   e;
        @(negedge clk);
        rst = r; imem_ready = rdy; id_stall = stl; redirect = rd; redirect_pc = rpc;
        rv = !r && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(mem_q[0].addr) : 16'($urandom);
        #1;
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = fetch_valid;
        obs_pc = fetch_pc; obs_inst = fetch_inst;

        exp_req = !r && !rd && ((mem_q.size() + out_q.size()) < DEPTH);
        check("imem_req", 16'(obs_req), 16'(exp_req));
        check("imem_addr", obs_addr, m_pc);
        if (hold_prev) check("addr_hold", obs_addr, addr_prev);
        if (out_q.size() > 0) begin
            check("fetch_valid", 16'(obs_valid), 16'd1);
            check("fetch_pc", obs_pc, out_q[0].pc);
            check("fetch_inst", obs_inst, out_q[0].inst);
        end else begin
            check("fetch_valid", 16'(obs_valid), 16'd0);
            check("fetch_pc_idle", obs_pc, 16'h0000);
            check("fetch_inst_idle", obs_inst, NOP);
        end
        hold_prev = obs_req && !rdy && !rd && !r;
        addr_prev = obs_addr;
        if (watch && obs_valid && (obs_pc == 16'h0010 || obs_pc == 16'h0011)) bad_seen = 1'b1;
        if (obs_valid && !stl && !rd && !r) begin
            $display("cycle %0d: pop pc=%h inst=%h", cyc, obs_pc, obs_inst);
            if (have_prev_pop && prev_pop == 16'hFFFF && obs_pc == 16'h0000) saw_wrap = 1'b1;
            prev_pop = obs_pc;
            have_prev_pop = 1'b1;
        end

        @(posedge clk);
        if (r) begin
            mem_q.delete();
            out_q.delete();
            m_pc = RESET_PC;
            epoch++;
        end else begin
            acc = exp_req && rdy;
            pop = !rd && !stl && (out_q.size() > 0);
            if (pop) void'(out_q.pop_front());
            if (rv) begin
                head = mem_q.pop_front();
                if (!rd && head.epoch == epoch) begin
                    e.pc = head.addr;
                    e.inst = mem_word(head.addr);
                    out_q.push_back(e);
                end
            end
            if (acc) begin
                head.addr = m_pc; head.epoch = epoch; head.due = cyc + lat;
                mem_q.push_back(head);
            end
            if (rd) begin
                out_q.delete();
                epoch++;
                m_pc = rpc;
            end else if (acc) begin
                m_pc = m_pc + 16'd1;
            end
        end
        cyc++;
    endtask

    task automatic quiesce();
        int n;
        n = 0;
        while ((mem_q.size() > 0 || out_q.size() > 0) && n < 50) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
            n++;
        end
        check("quiesce_timeout", 16'(n < 50), 16'd1);
    endtask

    // ready, stall, exp_req, exp_addr, exp_valid, exp_pc (1-cycle memory latency)
    task automatic set_vec(input int i, input logic rdy, input logic stl, input logic er,
                           input logic [15:0] ea, input logic ev, input logic [15:0] ep);
        tbl[i].ready = rdy; tbl[i].stall = stl; tbl[i].exp_req = er;
        tbl[i].exp_addr = ea; tbl[i].exp_valid = ev; tbl[i].exp_pc = ep;
    endtask

    initial begin
        bit found;
        set_vec(0,  1, 0, 1, 16'h0000, 0, 16'h0000);
        set_vec(1,  1, 0, 1, 16'h0001, 0, 16'h0000);
        set_vec(2,  1, 0, 0, 16'h0002, 1, 16'h0000);
        set_vec(3,  1, 0, 1, 16'h0002, 1, 16'h0001);
        set_vec(4,  1, 0, 1, 16'h0003, 0, 16'h0000);
        set_vec(5,  1, 0, 0, 16'h0004, 1, 16'h0002);
        set_vec(6,  1, 0, 1, 16'h0004, 1, 16'h0003);
        set_vec(7,  1, 0, 1, 16'h0005, 0, 16'h0000);
        set_vec(8,  1, 1, 0, 16'h0006, 1, 16'h0004);
        set_vec(9,  1, 1, 0, 16'h0006, 1, 16'h0004);
        set_vec(10, 1, 1, 0, 16'h0006, 1, 16'h0004);
        set_vec(11, 1, 1, 0, 16'h0006, 1, 16'h0004);
        set_vec(12, 1, 1, 0, 16'h0006, 1, 16'h0004);
        set_vec(13, 1, 1, 0, 16'h0006, 1, 16'h0004);
        set_vec(14, 1, 0, 0, 16'h0006, 1, 16'h0004);
        set_vec(15, 1, 0, 1, 16'h0006, 1, 16'h0005);
        set_vec(16, 1, 0, 1, 16'h0007, 0, 16'h0000);
        set_vec(17, 1, 0, 0, 16'h0008, 1, 16'h0006);

        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
        @(posedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // Directed stream and stall table.
        lat = 1;
        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].ready, tbl[i].stall, 1'b0, 16'h0);
            check("tbl_req", 16'(obs_req), 16'(tbl[i].exp_req));
            check("tbl_addr", obs_addr, tbl[i].exp_addr);
            check("tbl_valid", 16'(obs_valid), 16'(tbl[i].exp_valid));
            check("tbl_pc", obs_pc, tbl[i].exp_valid ? tbl[i].exp_pc : 16'h0000);
            check("tbl_inst", obs_inst, tbl[i].exp_valid ? mem_word(tbl[i].exp_pc) : NOP);
        end

        // Redirect with two latency-3 fetches in flight.
        quiesce();
        lat = 3;
        watch = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("flight_a", obs_addr, 16'h0010);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("flight_b", obs_addr, 16'h0011);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            found = obs_valid;
        end
        check("redir_found", 16'(found), 16'd1);
        check("redir_first_pc", obs_pc, 16'h0040);
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        watch = 1'b0;
        check("stale_emitted", 16'(bad_seen), 16'd0);

        // Redirect coinciding with a response and a stall.
        quiesce();
        lat = 2;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0200);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        check("rr_valid", 16'(obs_valid), 16'd0);
        check("rr_req", 16'(obs_req), 16'd1);
        check("rr_addr", obs_addr, 16'h0200);

        // PC wrap with random ready and stall.
        quiesce();
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE);
        for (int i = 0; i < 80; i++) begin
            lat = 1 + int'($urandom_range(0, 2));
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0, 16'h0);
        end
        check("pc_wrap", 16'(saw_wrap), 16'd1);

        // Reset mid-stream with two entries buffered.
        quiesce();
        lat = 1;
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        check("rst_pre_valid", 16'(obs_valid), 16'd1);
        check("rst_req", 16'(obs_req), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("rst_valid", 16'(obs_valid), 16'd0);
        check("rst_inst", obs_inst, NOP);
        check("rst_addr", obs_addr, RESET_PC);

        // Random traffic with redirects, stalls, variable latency and rare resets.
        for (int i = 0; i < 1500; i++) begin
            lat = 1 + int'($urandom_range(0, 3));
            step(1'($urandom_range(0, 499) == 0),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 24) == 0),
                 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
